// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, reset vector and instruction-word types.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [31:0]     instr_t;

  localparam addr_t RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer with flush; exposes occupancy so the producer can
// decide when a push is allowed. Caller guarantees no push when full without pop.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is reset too so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads the combinational imem and buffers {pc, instr}
// for decode. Redirects flush the buffer and restart fetch at the aligned target.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int                  MP_WIDTH      = XLEN,
  parameter logic [MP_WIDTH-1:0] MP_RESET_PC   = RESET_PC,
  parameter int                  MP_FIFO_DEPTH = 2
) (
  input  logic                iclk,
  input  logic                irst_n,
  output logic [MP_WIDTH-1:0] oimem_addr,
  input  logic [MP_WIDTH-1:0] iimem_data,
  input  logic                iredirect,
  input  logic [MP_WIDTH-1:0] iredirect_pc,
  output logic                odec_valid,
  input  logic                idec_ready,
  output logic [MP_WIDTH-1:0] odec_instr,
  output logic [MP_WIDTH-1:0] odec_pc,
  output logic [MP_WIDTH-1:0] odec_pc_plus4,
  output logic                omisalign
);

  localparam int CW = $clog2(MP_FIFO_DEPTH) + 1;
  localparam int EW = 3 * MP_WIDTH;

  logic [MP_WIDTH-1:0] pc_q;
  logic [MP_WIDTH-1:0] pc_next_seq;
  logic [CW-1:0]       count;
  logic                misalign_q;
  logic                push;
  logic                pop;
  logic [EW-1:0]       wr_entry;
  logic [EW-1:0]       rd_entry;

  // Decode handshake: an entry transfers on any cycle where odec_valid and
  // idec_ready are both high; odec_valid never depends on idec_ready, and a
  // transfer coinciding with iredirect is void (decode must drop it).
  assign odec_valid  = (count != '0);
  assign pop         = odec_valid & idec_ready;
  assign push        = ~iredirect & ((count < CW'(MP_FIFO_DEPTH)) | pop);
  assign pc_next_seq = pc_q + MP_WIDTH'(INSTR_BYTES);

  // pc+4 travels with the entry so the head fields all clear together on reset.
  assign wr_entry = {pc_next_seq, pc_q, iimem_data};

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      pc_q       <= MP_RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= iredirect & (iredirect_pc[1:0] != 2'b00);
      if (iredirect) begin
        pc_q <= {iredirect_pc[MP_WIDTH-1:2], 2'b00};
      end else if (push) begin
        pc_q <= pc_next_seq;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (MP_FIFO_DEPTH)
  ) u_fifo (
    .clk   (iclk),
    .rst_n (irst_n),
    .flush (iredirect),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .count (count)
  );

  assign oimem_addr    = pc_q;
  assign omisalign     = misalign_q;
  assign odec_pc_plus4 = rd_entry[EW-1 -: MP_WIDTH];
  assign odec_pc       = rd_entry[2*MP_WIDTH-1 -: MP_WIDTH];
  assign odec_instr    = rd_entry[MP_WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based fetch model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_instr_fetch;

  localparam int W     = 32;
  localparam int DEPTH = 2;

  logic         iclk;
  logic         irst_n;
  logic [W-1:0] oimem_addr;
  logic [W-1:0] iimem_data;
  logic         iredirect;
  logic [W-1:0] iredirect_pc;
  logic         odec_valid;
  logic         idec_ready;
  logic [W-1:0] odec_instr;
  logic [W-1:0] odec_pc;
  logic [W-1:0] odec_pc_plus4;
  logic         omisalign;

  int n_pass  = 0;
  int n_total = 0;

  instr_fetch #(
    .MP_WIDTH      (W),
    .MP_RESET_PC   (32'h0000_0000),
    .MP_FIFO_DEPTH (DEPTH)
  ) dut (
    .iclk          (iclk),
    .irst_n        (irst_n),
    .oimem_addr    (oimem_addr),
    .iimem_data    (iimem_data),
    .iredirect     (iredirect),
    .iredirect_pc  (iredirect_pc),
    .odec_valid    (odec_valid),
    .idec_ready    (idec_ready),
    .odec_instr    (odec_instr),
    .odec_pc       (odec_pc),
    .odec_pc_plus4 (odec_pc_plus4),
    .omisalign     (omisalign)
  );

  // ---------------- clock / reset ----------------
  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // ---------------- instruction memory ----------------
  function automatic logic [W-1:0] imem_word(input logic [W-1:0] a);
    case (a)
      32'h00: return 32'h0050_0093;
      32'h04: return 32'h0010_8113;
      32'h08: return 32'h0020_81B3;
      32'h0C: return 32'h0031_0233;
      32'h10: return 32'h0041_82B3;
      32'h14: return 32'h0052_0333;
      default: return (a * 32'h0001_0003) ^ 32'hC3A5_5A3C;
    endcase
  endfunction

  assign iimem_data = imem_word(oimem_addr);

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  // exp_q holds the PCs of the instructions that should be waiting for decode.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_pc;
  logic         m_mis;

  always @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      exp_q.delete();
      m_pc  = 32'h0000_0000;
      m_mis = 1'b0;
    end else if (iredirect) begin
      exp_q.delete();
      m_pc  = iredirect_pc & 32'hFFFF_FFFC;
      m_mis = (iredirect_pc % 4) != 0;
    end else begin
      m_mis = 1'b0;
      if (exp_q.size() > 0 && idec_ready) void'(exp_q.pop_front());
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(m_pc);
        m_pc = m_pc + 4;
      end
    end
  end

  // Compare process: outputs are settled mid-cycle.
  always @(negedge iclk) begin
    chk("cmp_valid", {31'b0, odec_valid}, {31'b0, exp_q.size() > 0});
    chk("cmp_imem_addr", oimem_addr, m_pc);
    chk("cmp_misalign", {31'b0, omisalign}, {31'b0, m_mis});
    if (exp_q.size() > 0) begin
      chk("cmp_pc", odec_pc, exp_q[0]);
      chk("cmp_instr", odec_instr, imem_word(exp_q[0]));
      chk("cmp_pc_plus4", odec_pc_plus4, exp_q[0] + 32'd4);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic redir, input logic [W-1:0] tgt);
    idec_ready   = rdy;
    iredirect    = redir;
    iredirect_pc = tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    irst_n = 1'b0;
    drive(1'b0, 1'b0, '0);
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_valid", {31'b0, odec_valid}, 32'd0);
    chk("rst_pc", odec_pc, 32'h0);
    chk("rst_instr", odec_instr, 32'h0);
    chk("rst_pc_plus4", odec_pc_plus4, 32'h0);
    irst_n = 1'b1;
    #1;
    chk("rel_imem_addr", oimem_addr, 32'h0);

    // Streaming with decode always ready
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stream_valid", {31'b0, odec_valid}, 32'd1);
      chk("stream_pc", odec_pc, 32'(4 * i));
      chk("stream_plus4", odec_pc_plus4, 32'(4 * i + 4));
    end
    chk("stream_w5", odec_instr, 32'h0052_0333);

    // Decode stall: buffer fills, PC freezes, then resumes without gaps
    drive(1'b0, 1'b0, '0);
    repeat (5) tick();
    chk("stall_imem_addr", oimem_addr, 32'h1C);
    chk("stall_head_pc", odec_pc, 32'h14);
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("resume_pc", odec_pc, 32'(32'h18 + 4 * i));
    end

    // Redirect while full
    drive(1'b0, 1'b0, '0);
    repeat (3) tick();
    drive(1'b1, 1'b1, 32'h40);
    tick();
    chk("redir_valid", {31'b0, odec_valid}, 32'd0);
    chk("redir_imem_addr", oimem_addr, 32'h40);
    drive(1'b1, 1'b0, '0);
    tick();
    chk("redir_pc", odec_pc, 32'h40);
    chk("redir_misalign", {31'b0, omisalign}, 32'd0);

    // Misaligned target
    drive(1'b1, 1'b1, 32'h42);
    tick();
    chk("mis_pulse", {31'b0, omisalign}, 32'd1);
    chk("mis_imem_addr", oimem_addr, 32'h40);
    drive(1'b1, 1'b0, '0);
    tick();
    chk("mis_clear", {31'b0, omisalign}, 32'd0);
    chk("mis_pc", odec_pc, 32'h40);

    // Back-to-back redirects: last wins
    drive(1'b1, 1'b1, 32'h80);
    tick();
    chk("b2b_valid0", {31'b0, odec_valid}, 32'd0);
    drive(1'b1, 1'b1, 32'hC0);
    tick();
    chk("b2b_valid1", {31'b0, odec_valid}, 32'd0);
    chk("b2b_imem_addr", oimem_addr, 32'hC0);
    drive(1'b1, 1'b0, '0);
    tick();
    chk("b2b_pc", odec_pc, 32'hC0);

    // PC wrap at top of address space
    drive(1'b1, 1'b1, 32'hFFFF_FFFC);
    tick();
    drive(1'b1, 1'b0, '0);
    tick();
    chk("wrap_pc", odec_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", odec_pc_plus4, 32'h0);
    chk("wrap_imem_addr", oimem_addr, 32'h0);
    tick();
    chk("wrap_next_pc", odec_pc, 32'h0);

    // Mixed traffic, checked by the model
    for (int i = 0; i < 150; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            32'($urandom_range(0, 1023)));
      tick();
    end
    drive(1'b1, 1'b0, '0);
    tick();

    // Async reset mid-cycle while full
    drive(1'b0, 1'b0, '0);
    repeat (3) tick();
    #2;
    irst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, odec_valid}, 32'd0);
    chk("arst_pc", odec_pc, 32'h0);
    chk("arst_instr", odec_instr, 32'h0);
    chk("arst_plus4", odec_pc_plus4, 32'h0);
    chk("arst_imem_addr", oimem_addr, 32'h0);
    chk("arst_misalign", {31'b0, omisalign}, 32'd0);
    tick();
    irst_n = 1'b1;
    drive(1'b1, 1'b0, '0);
    tick();
    chk("arst_rel_valid", {31'b0, odec_valid}, 32'd1);
    chk("arst_rel_pc", odec_pc, 32'h0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
